// File: rtl/btn_event_gen.sv
// Button level to press/release event converter with auto-repeat, a press-driven
// counter, and a single-beat valid/ready output register for a FIFO write port.
module btn_event_gen #(
  parameter int unsigned        Width_g        = 3,
  parameter int unsigned        DataWidth_g    = 4,
  parameter real                ClkFrequency_g = 10.0e6,
  parameter real                RepeatDelay_g  = 0.5,
  parameter real                RepeatPeriod_g = 0.1,
  parameter logic [Width_g-1:0] RepeatEnable_g = '1,
  parameter int unsigned        IncIdx_g       = 2,
  parameter int unsigned        PushIdx_g      = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [Width_g-1:0]     In_Levels,
  output logic [Width_g-1:0]     Out_Press,
  output logic [Width_g-1:0]     Out_Release,
  output logic [DataWidth_g-1:0] Data_Value,
  output logic                   Out_Valid,
  output logic [DataWidth_g-1:0] Out_Data,
  input  logic                   Out_Ready,
  output logic                   Out_Dropped
);

  localparam int DelayCyc  = int'(ClkFrequency_g * RepeatDelay_g);
  localparam int PeriodCyc = int'(ClkFrequency_g * RepeatPeriod_g);
  localparam int MaxCyc    = (DelayCyc > PeriodCyc) ? DelayCyc : PeriodCyc;
  localparam int TimerW    = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

  localparam logic [TimerW-1:0] DelayLoad  = TimerW'(DelayCyc - 1);
  localparam logic [TimerW-1:0] PeriodLoad = TimerW'(PeriodCyc - 1);

  if (DelayCyc < 2 || PeriodCyc < 2) begin : g_bad_timing
    $error("btn_event_gen: repeat delay and period must each be at least 2 clock cycles");
  end
  if (IncIdx_g >= Width_g || PushIdx_g >= Width_g) begin : g_bad_index
    $error("btn_event_gen: IncIdx_g and PushIdx_g must address an existing button");
  end

  typedef enum logic [1:0] {StLocked, StIdle, StDelay, StRepeat} state_e;

  logic [Width_g-1:0]     press_d, press_q;
  logic [Width_g-1:0]     release_d, release_q;
  logic [DataWidth_g-1:0] count_d, count_q;
  logic [DataWidth_g-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   dropped_d, dropped_q;

  for (genvar i = 0; i < Width_g; i++) begin : g_btn
    state_e            state_d, state_q;
    logic [TimerW-1:0] timer_d, timer_q;
    logic              level;
    logic              press_b, release_b;

    assign level = In_Levels[i];

    always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      press_b   = 1'b0;
      release_b = 1'b0;
      case (state_q)
        // Locked swallows a level held through reset until it is seen released.
        StLocked: begin
          if (!level) state_d = StIdle;
        end
        StIdle: begin
          if (level) begin
            state_d = StDelay;
            timer_d = DelayLoad;
            press_b = 1'b1;
          end
        end
        StDelay: begin
          if (!level) begin
            state_d   = StIdle;
            release_b = 1'b1;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TimerW'(1);
          end else if (RepeatEnable_g[i]) begin
            state_d = StRepeat;
            timer_d = PeriodLoad;
            press_b = 1'b1;
          end
        end
        StRepeat: begin
          if (!level) begin
            state_d   = StIdle;
            release_b = 1'b1;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TimerW'(1);
          end else begin
            timer_d = PeriodLoad;
            press_b = 1'b1;
          end
        end
        default: state_d = StLocked;
      endcase
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_q <= StLocked;
        timer_q <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    assign press_d[i]   = press_b;
    assign release_d[i] = release_b;
  end

  // Works off the registered press pulses, so a same-cycle increment is not yet visible.
  always_comb begin
    count_d   = count_q + DataWidth_g'(press_q[IncIdx_g]);
    data_d    = data_q;
    valid_d   = valid_q;
    dropped_d = 1'b0;
    if (press_q[PushIdx_g]) begin
      if (!valid_q || Out_Ready) begin
        data_d  = count_q;
        valid_d = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      press_q   <= '0;
      release_q <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign Out_Press   = press_q;
  assign Out_Release = release_q;
  assign Data_Value  = count_q;
  assign Out_Valid   = valid_q;
  assign Out_Data    = data_q;
  assign Out_Dropped = dropped_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: two instances (full and partial auto-repeat) checked every cycle
// against a hold-time based model, plus directed scenarios with literal expectations.
module tb_btn_event_gen;

  localparam int D = 10;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lv  = 3'b000;
  logic       rdy = 1'b0;

  logic [2:0] o_press [2];
  logic [2:0] o_rel   [2];
  logic [3:0] o_cnt   [2];
  logic [3:0] o_data  [2];
  logic       o_valid [2];
  logic       o_drop  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_event_gen #(
    .Width_g(3), .DataWidth_g(4), .ClkFrequency_g(1000.0), .RepeatDelay_g(0.01),
    .RepeatPeriod_g(0.004), .RepeatEnable_g(3'b111), .IncIdx_g(2), .PushIdx_g(0)
  ) dut (
    .Clk(clk), .Rst(rst), .In_Levels(lv), .Out_Press(o_press[0]), .Out_Release(o_rel[0]),
    .Data_Value(o_cnt[0]), .Out_Valid(o_valid[0]), .Out_Data(o_data[0]), .Out_Ready(rdy),
    .Out_Dropped(o_drop[0])
  );

  btn_event_gen #(
    .Width_g(3), .DataWidth_g(4), .ClkFrequency_g(1000.0), .RepeatDelay_g(0.01),
    .RepeatPeriod_g(0.004), .RepeatEnable_g(3'b011), .IncIdx_g(2), .PushIdx_g(0)
  ) dut_nr (
    .Clk(clk), .Rst(rst), .In_Levels(lv), .Out_Press(o_press[1]), .Out_Release(o_rel[1]),
    .Data_Value(o_cnt[1]), .Out_Valid(o_valid[1]), .Out_Data(o_data[1]), .Out_Ready(rdy),
    .Out_Dropped(o_drop[1])
  );

  // Model: per button, whether it has been seen released since reset, whether a press run
  // is in progress, and how many cycles the run has lasted since its initial press pulse.
  bit         armed  [2][3];
  bit         active [2][3];
  int         age    [2][3];
  logic [2:0] m_press [2];
  logic [2:0] m_rel   [2];
  logic [3:0] m_cnt   [2];
  logic [3:0] m_data  [2];
  logic       m_valid [2];
  logic       m_drop  [2];
  bit         started = 1'b0;

  function automatic bit rep_en(int u, int b);
    return (u == 0) || (b != 2);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] np;
    logic [2:0] nr;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        for (int b = 0; b < 3; b++) begin
          armed[u][b]  = 1'b0;
          active[u][b] = 1'b0;
          age[u][b]    = 0;
        end
        m_press[u] = '0; m_rel[u] = '0; m_cnt[u] = '0;
        m_data[u]  = '0; m_valid[u] = 1'b0; m_drop[u] = 1'b0;
      end else begin
        np = '0;
        nr = '0;
        if (m_press[u][0]) begin
          if (!m_valid[u] || rdy) begin
            m_valid[u] = 1'b1;
            m_data[u]  = m_cnt[u];
            m_drop[u]  = 1'b0;
          end else begin
            m_drop[u] = 1'b1;
          end
        end else begin
          m_drop[u] = 1'b0;
          if (m_valid[u] && rdy) m_valid[u] = 1'b0;
        end
        if (m_press[u][2]) m_cnt[u] = m_cnt[u] + 4'd1;
        for (int b = 0; b < 3; b++) begin
          if (!armed[u][b]) begin
            if (!lv[b]) armed[u][b] = 1'b1;
          end else if (!active[u][b]) begin
            if (lv[b]) begin
              active[u][b] = 1'b1;
              age[u][b]    = 0;
              np[b]        = 1'b1;
            end
          end else if (!lv[b]) begin
            active[u][b] = 1'b0;
            nr[b]        = 1'b1;
          end else begin
            age[u][b]++;
            if (rep_en(u, b) && age[u][b] >= D && (age[u][b] - D) % P == 0) np[b] = 1'b1;
          end
        end
        m_press[u] = np;
        m_rel[u]   = nr;
      end
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("press[%0d]", u),   32'(o_press[u]), 32'(m_press[u]));
        check($sformatf("release[%0d]", u), 32'(o_rel[u]),   32'(m_rel[u]));
        check($sformatf("count[%0d]", u),   32'(o_cnt[u]),   32'(m_cnt[u]));
        check($sformatf("valid[%0d]", u),   32'(o_valid[u]), 32'(m_valid[u]));
        check($sformatf("drop[%0d]", u),    32'(o_drop[u]),  32'(m_drop[u]));
        if (m_valid[u]) check($sformatf("data[%0d]", u), 32'(o_data[u]), 32'(m_data[u]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tap(int b);
    lv[b] = 1'b1;
    tick(2);
    lv[b] = 1'b0;
    tick(2);
  endtask

  logic [31:0] pv;
  logic [31:0] nv;

  initial begin
    // Button 0 held through reset, released, then pressed.
    rst = 1'b1; lv = 3'b001; rdy = 1'b0;
    tick(3);
    check("reset_press", 32'(o_press[0]), 32'd0);
    check("reset_count", 32'(o_cnt[0]), 32'd0);
    rst = 1'b0;
    tick(5);
    check("held_no_press", 32'(o_press[0]), 32'd0);
    lv[0] = 1'b0;
    tick(3);
    lv[0] = 1'b1;
    tick(1);
    check("first_press", 32'(o_press[0]), 32'b001);
    check("model_first_press", 32'(m_press[0]), 32'b001);
    lv[0] = 1'b0;
    tick(1);
    rdy = 1'b1;
    tick(2);
    rdy = 1'b0;

    // Hold button 2 for 30 cycles after its press pulse.
    pv = '0;
    nv = '0;
    lv[2] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      pv[k] = o_press[0][2];
      nv[k] = o_press[1][2];
    end
    lv[2] = 1'b0;
    tick(1);
    check("repeat_times", pv, 32'h0444_4401);
    check("norepeat_times", nv, 32'h0000_0001);
    check("repeat_release", 32'(o_rel[0]), 32'b100);
    check("norepeat_release", 32'(o_rel[1]), 32'b100);
    check("repeat_count", 32'(o_cnt[0]), 32'd6);
    check("norepeat_count", 32'(o_cnt[1]), 32'd1);
    check("model_repeat_count", 32'(m_cnt[0]), 32'd6);

    // Stream load, drop, and clear.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    repeat (3) tap(2);
    tap(0);
    check("load_valid", 32'(o_valid[0]), 32'd1);
    check("load_data", 32'(o_data[0]), 32'd3);
    lv[0] = 1'b1;
    tick(2);
    check("drop_pulse", 32'(o_drop[0]), 32'd1);
    check("drop_data_kept", 32'(o_data[0]), 32'd3);
    lv[0] = 1'b0;
    tick(2);
    check("drop_single_cycle", 32'(o_drop[0]), 32'd0);
    rdy = 1'b1;
    tick(1);
    check("clear_valid", 32'(o_valid[0]), 32'd0);

    // Simultaneous push and increment, then counter wrap.
    repeat (4) tap(2);
    lv = 3'b101;
    tick(2);
    check("simul_data", 32'(o_data[0]), 32'd7);
    check("simul_count", 32'(o_cnt[0]), 32'd8);
    lv = 3'b000;
    tick(2);
    repeat (7) tap(2);
    check("count_15", 32'(o_cnt[0]), 32'd15);
    tap(2);
    check("count_wrap", 32'(o_cnt[0]), 32'd0);
    repeat (15) tap(2);
    check("count_after_wrap", 32'(o_cnt[0]), 32'd15);

    // Reset while a beat is pending and button 2 is repeating.
    rdy = 1'b0;
    tap(0);
    lv[2] = 1'b1;
    tick(15);
    check("pre_reset_valid", 32'(o_valid[0]), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_press", 32'(o_press[0]), 32'd0);
    check("rst_valid", 32'(o_valid[0]), 32'd0);
    check("rst_count", 32'(o_cnt[0]), 32'd0);
    check("rst_data", 32'(o_data[0]), 32'd0);
    rst = 1'b0;
    tick(12);
    check("locked_after_rst", 32'(o_press[0]), 32'd0);
    lv[2] = 1'b0;
    tick(2);
    lv[2] = 1'b1;
    tick(1);
    check("press_after_rearm", 32'(o_press[0]), 32'b100);
    lv[2] = 1'b0;
    tick(2);

    // Random levels, ready and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 15) == 0) lv[b] = ~lv[b];
      end
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Converts debounced button/switch levels into single-cycle press/release events, with optional auto-repeat while a button is held.
- Maintains a press-driven data counter and emits counter samples as a valid/ready stream beat, for direct connection to a sync FIFO write port.
- Sits between the switch debouncer and the FIFO in board-level tutorial/demo tops, replacing ad-hoc edge-detect and counter logic.

Parameters:
- Width_g, 3, number of button inputs (1..16).
- DataWidth_g, 4, width of the data counter and Out_Data.
- ClkFrequency_g, 10.0e6, Clk frequency in Hz (real).
- RepeatDelay_g, 0.5, hold time in seconds before the first auto-repeat (real).
- RepeatPeriod_g, 0.1, auto-repeat interval in seconds (real).
- RepeatEnable_g, all '1', Width_g-bit mask; bit i enables auto-repeat for button i.
- IncIdx_g, 2, index of the button whose presses increment the counter.
- PushIdx_g, 0, index of the button whose presses emit a stream beat.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset: synchronous, active-high; clock Clk.
- In_Levels  in  Width_g  debounced, synchronous button levels (1 = pressed).
- Out_Press  out  Width_g  one-cycle pulse per press or auto-repeat.
- Out_Release  out  Width_g  one-cycle pulse on release.
- Data_Value  out  DataWidth_g  current counter value.
- Out_Valid  out  1  stream beat valid.
- Out_Data  out  DataWidth_g  stream beat data.
- Out_Ready  in  1  downstream ready.
- Out_Dropped  out  1  one-cycle pulse when a push press is lost.

Behaviour:
- Timer constants: DelayCyc = integer(ClkFrequency_g*RepeatDelay_g); PeriodCyc = integer(ClkFrequency_g*RepeatPeriod_g). Both must be >= 2; elaboration fails (assertion) otherwise.
- Each button has an independent FSM with states Locked, Idle, Delay and Repeat, plus one shared-width timer per button.
- Reset: every FSM goes to Locked, and all outputs are 0 (Out_Press, Out_Release, Data_Value, Out_Valid, Out_Data, Out_Dropped).
- Locked: when level = 0, go to Idle with no event. A button held through reset therefore never produces a press or release.
- Idle: when level = 1, go to Delay, load timer with DelayCyc-1, and pulse Out_Press(i).
- Delay: level = 0 goes to Idle and pulses Out_Release(i). Otherwise the timer decrements. When the timer reaches 0 and RepeatEnable_g(i)=1, go to Repeat, load timer with PeriodCyc-1, and pulse Out_Press(i). If repeat is disabled, stay in Delay with the timer held at 0.
- Repeat: level = 0 goes to Idle and pulses Out_Release(i). When the timer reaches 0, pulse Out_Press(i) and reload PeriodCyc-1.
- Latency: outputs are registered. An edge of In_Levels sampled at clock k produces its pulse in cycle k+1.
- Auto-repeat timing: first repeat pulse comes DelayCyc cycles after the initial press pulse; subsequent repeats are every PeriodCyc cycles.
- Counter: Data_Value increments by 1 on each Out_Press(IncIdx_g) assertion, repeats included. Wraps from 2^DataWidth_g-1 to 0.
- Stream load: on Out_Press(PushIdx_g), if Out_Valid=0, or Out_Valid=1 with Out_Ready=1 in the same cycle, then Out_Data <= Data_Value as registered in that cycle and Out_Valid <= 1.
- Stream drop: otherwise the beat is discarded and Out_Dropped pulses for one cycle. Out_Data is unchanged.
- Stream clear: Out_Valid=1 and Out_Ready=1 with no new load gives Out_Valid <= 0. Out_Data remains stable while Out_Valid=1 and Out_Ready=0.
- Simultaneous increment and push press in the same cycle: the beat carries the pre-increment value.
- Out_Ready is ignored while Out_Valid=0.
- Reset mid-operation: a pending beat is discarded, the counter is cleared, and all FSMs go to Locked. Held buttons emit nothing until released and pressed again.

Test Plan (ClkFrequency_g=1000.0, RepeatDelay_g=0.01 -> DelayCyc=10, RepeatPeriod_g=0.004 -> PeriodCyc=4, Width_g=3, DataWidth_g=4):
- Button 0 held high through reset, released 5 cycles after reset, then pressed 3 cycles later -> no pulses until that press; then Out_Press(0) for 1 cycle, one cycle after the sampled rise.
- Hold button 2 for 25 cycles after its press pulse -> Out_Press(2) at relative cycles 0, 10, 14, 18, 22. Data_Value 0->5. On release, one Out_Release(2) pulse follows.
- Set RepeatEnable_g="011" and hold button 2 for 30 cycles -> exactly one Out_Press(2), and Data_Value=1.
- Out_Ready=0; press button 2 three times, then button 0 -> Out_Valid=1 with Out_Data=3. Press button 0 again -> Out_Dropped pulses and Out_Data stays 3. Set Out_Ready=1 -> Out_Valid drops after one cycle.
- Press buttons 0 and 2 in the same cycle with Data_Value=7 and Out_Ready=1 -> Out_Data=7, Data_Value=8. Press button 2 sixteen more times from 15 -> Data_Value wraps to 0 at the first press.
- Assert Rst while Out_Valid=1 and button 2 is in Repeat -> all outputs 0 next cycle; no Out_Press(2) until button 2 is released and pressed again.
